// File: rtl/rr_mult_pp_pipe.sv
// Two-stage redundant-radix digit multiplier: pp = a * b, one B digit per beat.
// Ports: clk, rst_n (sync), in_valid/in_ready + a/b, out_valid/out_ready + pp,
// out_last only when RR_PP_DIGIT_CNT_EN is defined (per-multiplication digit count).
module rr_mult_pp_pipe #(
  parameter int RADIX = 4,
  parameter int J = 0,
  parameter int NUM_DIGITS = 8,
  localparam int D = $clog2(RADIX) + 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [D*(J+3)-1:0] a,
  input  logic [D-1:0]       b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [D*(J+4)-1:0] pp
`ifdef RR_PP_DIGIT_CNT_EN
  ,
  output logic               out_last
`endif
);

  localparam int NA = J + 3;
  localparam int NP = J + 4;
  localparam int L = $clog2(RADIX);
  localparam int W = 2 * D;

  logic v1, v2, ld1, ld2;
  logic [D*NP-1:0] ev_n, od_n, ev_q, od_q, sum_n;

  assign ld2 = !v2 || out_ready;
  assign ld1 = !v1 || ld2;
  assign in_ready = ld1;
  assign out_valid = v2;

  if (RADIX == 2) begin : g_r2
    always_comb begin
      logic [1:0] ai;
      ai = '0;
      ev_n = '0;
      od_n = '0;
      for (int i = 0; i < NA; i++) begin
        ai = a[2*i +: 2];
        if (ai == 2'b10) ai = 2'b00;
        if (b == 2'b01)
          ev_n[2*i +: 2] = ai;
        else if (b == 2'b11)
          ev_n[2*i +: 2] = {ai[1] ^ ai[0], ai[0]};
      end
    end

    // Odd vector is identically zero here, so the sum is the even vector.
    assign sum_n = ev_q | od_q;
  end else begin : g_rn
    always_comb begin
      logic signed [D-1:0] ai, bi;
      logic signed [W-1:0] p, mag, hi, lo;
      ai = '0;
      bi = b;
      p = '0;
      mag = '0;
      hi = '0;
      lo = '0;
      ev_n = '0;
      od_n = '0;
      for (int i = 0; i < NA; i++) begin
        ai = a[D*i +: D];
        p = W'(ai) * W'(bi);
        // Quotient truncated toward zero, remainder keeps the sign of p.
        mag = p[W-1] ? -p : p;
        hi = mag >>> L;
        if (p[W-1]) hi = -hi;
        lo = p - (hi <<< L);
        if (i % 2 == 0) begin
          ev_n[D*i +: D] = lo[D-1:0];
          ev_n[D*(i+1) +: D] = hi[D-1:0];
        end else begin
          od_n[D*i +: D] = lo[D-1:0];
          od_n[D*(i+1) +: D] = hi[D-1:0];
        end
      end
    end

    localparam logic signed [W-1:0] RM1 = W'(RADIX - 1);
    localparam logic signed [W-1:0] ONE = W'(1);

    // Carry-free add: transfer t in {-1,0,1} chosen from the local digit
    // sum only. The top digit is a lone hi (|hi| <= RADIX-2), so no
    // transfer ever leaves the vector.
    always_comb begin
      logic signed [D-1:0] xd, yd;
      logic signed [W-1:0] w, t, tin, z;
      xd = '0;
      yd = '0;
      w = '0;
      t = '0;
      tin = '0;
      z = '0;
      sum_n = '0;
      for (int i = 0; i < NP; i++) begin
        xd = ev_q[D*i +: D];
        yd = od_q[D*i +: D];
        w = W'(xd) + W'(yd);
        if (w >= RM1)
          t = ONE;
        else if (w <= -RM1)
          t = -ONE;
        else
          t = '0;
        z = w - (t <<< L) + tin;
        sum_n[D*i +: D] = z[D-1:0];
        tin = t;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
      ev_q <= '0;
      od_q <= '0;
      pp <= '0;
    end else begin
      if (ld1) v1 <= in_valid;
      if (ld1 && in_valid) begin
        ev_q <= ev_n;
        od_q <= od_n;
      end
      if (ld2) v2 <= v1;
      if (ld2 && v1) pp <= sum_n;
    end
  end

`ifdef RR_PP_DIGIT_CNT_EN
  logic [7:0] cnt;
  logic l1, last;

  assign last = (cnt == 8'(NUM_DIGITS - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
      l1 <= 1'b0;
      out_last <= 1'b0;
    end else begin
      if (ld1 && in_valid) begin
        cnt <= last ? 8'd0 : cnt + 8'd1;
        l1 <= last;
      end
      if (ld2 && v1) out_last <= l1;
    end
  end
`endif

endmodule

// File: tb/tb_rr_mult_pp_pipe.sv
// Directed bench for rr_mult_pp_pipe: radix-4 (J=0) and radix-2 (J=1)
// instances, value checks, stall/backpressure, mid-stream reset, digit count.
module tb_rr_mult_pp_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  int n_tests = 0;
  int n_fail = 0;

  logic iv4, ir4, ov4, or4;
  logic [8:0] a4;
  logic [2:0] b4;
  logic [11:0] pp4;

  logic iv2, ir2, ov2, or2;
  logic [7:0] a2;
  logic [1:0] b2;
  logic [9:0] pp2;

`ifdef RR_PP_DIGIT_CNT_EN
  logic ol4, ol2;
`endif

  rr_mult_pp_pipe #(.RADIX(4), .J(0), .NUM_DIGITS(4)) u4 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(iv4), .in_ready(ir4), .a(a4), .b(b4),
    .out_valid(ov4), .out_ready(or4), .pp(pp4)
`ifdef RR_PP_DIGIT_CNT_EN
    , .out_last(ol4)
`endif
  );

  rr_mult_pp_pipe #(.RADIX(2), .J(1), .NUM_DIGITS(8)) u2 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(iv2), .in_ready(ir2), .a(a2), .b(b2),
    .out_valid(ov2), .out_ready(or2), .pp(pp2)
`ifdef RR_PP_DIGIT_CNT_EN
    , .out_last(ol2)
`endif
  );

  function automatic int dec4(input logic [11:0] v);
    int s = 0;
    for (int i = 0; i < 4; i++) begin
      logic signed [2:0] d;
      d = v[3*i +: 3];
      s += int'(d) * (1 << (2 * i));
    end
    return s;
  endfunction

  function automatic int dec2(input logic [9:0] v);
    int s = 0;
    for (int i = 0; i < 5; i++) begin
      if (v[2*i +: 2] == 2'b01) s += (1 << i);
      else if (v[2*i +: 2] == 2'b11) s -= (1 << i);
    end
    return s;
  endfunction

  function automatic logic bad4(input logic [11:0] v);
    logic r = 1'b0;
    for (int i = 0; i < 4; i++)
      if (v[3*i +: 3] == 3'b100) r = 1'b1;
    return r;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    iv4 = 0; or4 = 1; a4 = '0; b4 = '0;
    iv2 = 0; or2 = 1; a2 = '0; b2 = '0;
    repeat (2) @(negedge clk);
    n_tests++;
    if (ov4 !== 1'b0) begin
      n_fail++; $display("FAIL reset_ov4: got %b want 0", ov4);
    end
    n_tests++;
    if (pp4 !== 12'h0) begin
      n_fail++; $display("FAIL reset_pp4: got %h want 0", pp4);
    end
    n_tests++;
    if (ir4 !== 1'b1) begin
      n_fail++; $display("FAIL reset_ir4: got %b want 1", ir4);
    end
    n_tests++;
    if (ov2 !== 1'b0 || pp2 !== 10'h0) begin
      n_fail++; $display("FAIL reset_u2: got ov=%b pp=%h want 0/0", ov2, pp2);
    end
    rst_n = 1'b1;
  endtask

  // a digits written MSD..LSD. Second row: value(a) = -3+8-16 = -11.
  task automatic test_radix4();
    logic [8:0] ta [5];
    logic [2:0] tb [5];
    int te [5];
    ta = '{9'b011_011_011, 9'b111_010_101, 9'b101_101_101,
           9'b011_101_011, 9'b011_011_011};
    tb = '{3'b011, 3'b110, 3'b101, 3'b101, 3'b000};
    te = '{189, 22, 189, -117, 0};
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      iv4 = 1; a4 = ta[i]; b4 = tb[i]; or4 = 1;
      #1;
      n_tests++;
      if (ir4 !== 1'b1) begin
        n_fail++; $display("FAIL r4_in_ready[%0d]: got %b want 1", i, ir4);
      end
      @(negedge clk);
      iv4 = 0;
      n_tests++;
      if (ov4 !== 1'b0) begin
        n_fail++; $display("FAIL r4_early[%0d]: got %b want 0", i, ov4);
      end
      @(negedge clk);
      n_tests++;
      if (ov4 !== 1'b1 || dec4(pp4) !== te[i]) begin
        n_fail++;
        $display("FAIL r4_value[%0d]: got ov=%b val=%0d want 1/%0d",
                 i, ov4, dec4(pp4), te[i]);
      end
      n_tests++;
      if (bad4(pp4) !== 1'b0) begin
        n_fail++; $display("FAIL r4_digit[%0d]: got pp=%h want digits in -3..3", i, pp4);
      end
    end
  endtask

  task automatic test_radix2();
    logic [7:0] ta [3];
    logic [1:0] tb [3];
    logic [9:0] tp [3];
    int tv [3];
    ta = '{8'b01_00_11_01, 8'b00_01_10_01, 8'b01_00_11_01};
    tb = '{2'b11, 2'b01, 2'b10};
    tp = '{10'b00_11_00_01_11, 10'b00_00_01_00_01, 10'b0};
    tv = '{-7, 5, 0};
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      iv2 = 1; a2 = ta[i]; b2 = tb[i]; or2 = 1;
      @(negedge clk);
      iv2 = 0;
      @(negedge clk);
      n_tests++;
      if (ov2 !== 1'b1 || pp2 !== tp[i]) begin
        n_fail++;
        $display("FAIL r2_digits[%0d]: got ov=%b pp=%b want 1/%b", i, ov2, pp2, tp[i]);
      end
      n_tests++;
      if (dec2(pp2) !== tv[i]) begin
        n_fail++; $display("FAIL r2_value[%0d]: got %0d want %0d", i, dec2(pp2), tv[i]);
      end
    end
  endtask

  task automatic test_stall();
    int q[$];
    int sent = 0;
    int got = 0;
    logic hold = 1'b0;
    logic [11:0] hpp = '0;
    for (int c = 0; c < 60 && got < 10; c++) begin
      @(negedge clk);
      or4 = !(c >= 3 && c <= 6);
      iv4 = (sent < 10);
      if (sent < 10) begin
        a4 = {3'b000, 3'(sent / 4), 3'(sent % 4)};
        b4 = (sent % 2 != 0) ? 3'b101 : 3'b010;
      end
      #1;
      if (hold) begin
        n_tests++;
        if (ov4 !== 1'b1 || pp4 !== hpp) begin
          n_fail++;
          $display("FAIL stall_hold[c%0d]: got ov=%b pp=%h want 1/%h", c, ov4, pp4, hpp);
        end
      end
      if (c >= 3 && c <= 6) begin
        n_tests++;
        if (ir4 !== 1'b0) begin
          n_fail++; $display("FAIL stall_full[c%0d]: got in_ready=%b want 0", c, ir4);
        end
      end
      if (ov4 && or4) begin
        n_tests++;
        if (q.size() == 0) begin
          n_fail++; $display("FAIL stall_dup[c%0d]: got extra pp %0d want none", c, dec4(pp4));
        end else begin
          int e;
          e = q.pop_front();
          if (dec4(pp4) !== e) begin
            n_fail++; $display("FAIL stall_value[%0d]: got %0d want %0d", got, dec4(pp4), e);
          end
        end
        got++;
      end
      hold = ov4 && !or4;
      hpp = pp4;
      if (iv4 && ir4) begin
        q.push_back(sent * ((sent % 2 != 0) ? -3 : 2));
        sent++;
      end
    end
    iv4 = 0;
    or4 = 1;
    n_tests++;
    if (got !== 10) begin
      n_fail++; $display("FAIL stall_count: got %0d outputs want 10", got);
    end
    repeat (2) begin
      @(negedge clk);
      n_tests++;
      if (ov4 !== 1'b0) begin
        n_fail++; $display("FAIL stall_drained: got ov=%b want 0", ov4);
      end
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    or4 = 0; iv4 = 1; a4 = 9'b000_000_011; b4 = 3'b011;
    @(negedge clk);
    a4 = 9'b000_001_000; b4 = 3'b010;
    @(negedge clk);
    iv4 = 0;
    n_tests++;
    if (ov4 !== 1'b1 || ir4 !== 1'b0) begin
      n_fail++; $display("FAIL mid_inflight: got ov=%b ir=%b want 1/0", ov4, ir4);
    end
    rst_n = 0;
    @(negedge clk);
    n_tests++;
    if (ov4 !== 1'b0 || pp4 !== 12'h0) begin
      n_fail++; $display("FAIL mid_reset: got ov=%b pp=%h want 0/0", ov4, pp4);
    end
    rst_n = 1;
    or4 = 1;
    #1;
    n_tests++;
    if (ir4 !== 1'b1) begin
      n_fail++; $display("FAIL mid_ready: got %b want 1", ir4);
    end
    repeat (3) begin
      @(negedge clk);
      n_tests++;
      if (ov4 !== 1'b0) begin
        n_fail++; $display("FAIL mid_stale: got ov=%b pp=%h want 0", ov4, pp4);
      end
    end
  endtask

`ifdef RR_PP_DIGIT_CNT_EN
  task automatic test_last();
    int sent = 0;
    int got = 0;
    rst_n = 0;
    iv4 = 0;
    or4 = 1;
    @(negedge clk);
    rst_n = 1;
    a4 = 9'b000_000_001;
    b4 = 3'b001;
    for (int c = 0; c < 30 && got < 9; c++) begin
      @(negedge clk);
      iv4 = (sent < 9);
      #1;
      if (ov4) begin
        n_tests++;
        if (ol4 !== (got == 3 || got == 7)) begin
          n_fail++; $display("FAIL last[%0d]: got %b want %b", got, ol4, (got == 3 || got == 7));
        end
        got++;
      end
      if (iv4 && ir4) sent++;
    end
    iv4 = 0;
    n_tests++;
    if (got !== 9) begin
      n_fail++; $display("FAIL last_count: got %0d want 9", got);
    end
    n_tests++;
    if (u4.cnt !== 8'd1) begin
      n_fail++; $display("FAIL last_cnt: got %0d want 1", u4.cnt);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_radix4();
    test_radix2();
    test_stall();
    test_reset_mid();
`ifdef RR_PP_DIGIT_CNT_EN
    test_last();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
